// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;
  localparam int unsigned CNT_W        = 6;

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FIX,
    DONE,
    DZERO
  } state_t;

endpackage

// File: rtl/muldiv_counter.sv
// Iteration counter shared by the multiply and divide loops; flags the last step.
module muldiv_counter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Booth multiply / restoring divide engine with its sequencing FSM.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             hilo_write,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned AW = 2 * WIDTH + 1;

  state_t state, state_nxt;

  // Multiply uses acc as {A, Q, q-1}; divide uses acc[2W-1:0] as {rem, quo}.
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] opnd;
  logic             neg_q, neg_r;

  logic load_mult, load_div, cnt_en, cnt_last, wr_mult, wr_fix;

  logic [WIDTH-1:0] a_hi, rem, quo, rem_nxt, quo_nxt, q_fix, r_fix;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   booth_sum, div_trial;
  logic [AW-1:0]    mult_nxt, div_nxt;

  muldiv_counter #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (load_mult | load_div),
    .enable (cnt_en),
    .last   (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_mult  = 1'b0;
    load_div   = 1'b0;
    cnt_en     = 1'b0;
    wr_mult    = 1'b0;
    wr_fix     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    hilo_write = 1'b0;
    div_zero   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          done       = 1'b1;
          hilo_write = 1'b1;
        end
        if (mult_start) begin
          state_nxt = MULT;
          load_mult = 1'b1;
        end else if (div_start && (src_b != '0)) begin
          state_nxt = DIV;
          load_div  = 1'b1;
        end else if (div_start) begin
          state_nxt = DZERO;
        end else begin
          state_nxt = IDLE;
        end
      end
      MULT: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (cnt_last) begin
          wr_mult   = 1'b1;
          state_nxt = DONE;
        end
      end
      DIV: begin
        busy   = 1'b1;
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        busy      = 1'b1;
        wr_fix    = 1'b1;
        state_nxt = DONE;
      end
      DZERO: begin
        done      = 1'b1;
        div_zero  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Booth step: add/sub in W+1 bits so that subtracting the most negative
  // multiplicand cannot overflow; the arithmetic shift then drops the extra bit.
  always_comb begin
    a_hi      = acc[AW-1:WIDTH+1];
    booth_sum = {a_hi[WIDTH-1], a_hi};
    case (acc[1:0])
      2'b01:   booth_sum = {a_hi[WIDTH-1], a_hi} + {opnd[WIDTH-1], opnd};
      2'b10:   booth_sum = {a_hi[WIDTH-1], a_hi} - {opnd[WIDTH-1], opnd};
      default: booth_sum = {a_hi[WIDTH-1], a_hi};
    endcase
    mult_nxt = {booth_sum, acc[WIDTH:1]};
  end

  always_comb begin
    rem       = acc[2*WIDTH-1:WIDTH];
    quo       = acc[WIDTH-1:0];
    div_trial = {rem, quo[WIDTH-1]} - {1'b0, opnd};
    if (div_trial[WIDTH]) begin
      rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
    end else begin
      rem_nxt = div_trial[WIDTH-1:0];
    end
    quo_nxt = {quo[WIDTH-2:0], ~div_trial[WIDTH]};
    div_nxt = {1'b0, rem_nxt, quo_nxt};
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -rem : rem;
    a_mag   = src_a[WIDTH-1] ? -src_a : src_a;
    b_mag   = src_b[WIDTH-1] ? -src_b : src_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      if (load_mult) begin
        acc  <= {{WIDTH{1'b0}}, src_b, 1'b0};
        opnd <= src_a;
      end else if (load_div) begin
        acc   <= {{(WIDTH + 1){1'b0}}, a_mag};
        opnd  <= b_mag;
        neg_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
        neg_r <= src_a[WIDTH-1];
      end else if (state == MULT) begin
        acc <= mult_nxt;
      end else if (state == DIV) begin
        acc <= div_nxt;
      end
      if (wr_mult) begin
        hi_out <= mult_nxt[AW-1:WIDTH+1];
        lo_out <= mult_nxt[WIDTH:1];
      end
      if (wr_fix) begin
        hi_out <= r_fix;
        lo_out <= q_fix;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, hilo_write, div_zero;
  logic [31:0] hi_out, lo_out;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .done       (done),
    .hilo_write (hilo_write),
    .div_zero   (div_zero),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    longint p, q, r;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b != 0) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or budget expires).
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    int k, busy_n, exp_lat;
    bit ok_write;
    exp_lat  = !is_div ? 32 : ((b == 0) ? 0 : 33);
    ok_write = !is_div || (b != 0);
    src_a = a;
    src_b = b;
    mult_start = !is_div;
    div_start  = is_div;
    model(is_div, a, b);
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    k = 0;
    busy_n = 0;
    while (!done && k < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      k++;
    end
    check("latency", k, exp_lat);
    check("busy_cycles", busy_n, exp_lat);
    check("busy_at_done", busy, 0);
    check("hilo_write", hilo_write, ok_write);
    check("div_zero", div_zero, !ok_write);
    check("hi_out", hi_out, exp_hi);
    check("lo_out", lo_out, exp_lo);
  endtask

  task automatic after_op();
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("hi_hold", hi_out, exp_hi);
    check("lo_hold", lo_out, exp_lo);
  endtask

  initial begin
    int n_done;
    bit seen;
    logic [31:0] a, b;

    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo_write", hilo_write, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op(0, 32'h00000007, 32'hFFFFFFFD);
    check("m7x-3_hi", hi_out, 32'hFFFFFFFF);
    check("m7x-3_lo", lo_out, 32'hFFFFFFEB);
    after_op();
    run_op(1, 32'hFFFFFFF9, 32'h00000002);
    check("d-7/2_lo", lo_out, 32'hFFFFFFFD);
    check("d-7/2_hi", hi_out, 32'hFFFFFFFF);
    after_op();
    run_op(1, 32'h00000007, 32'hFFFFFFFE);
    check("d7/-2_lo", lo_out, 32'hFFFFFFFD);
    check("d7/-2_hi", hi_out, 32'h00000001);
    after_op();
    run_op(1, 32'h00000005, 32'h00000000);
    check("dz_hi_kept", hi_out, 32'h00000001);
    check("dz_lo_kept", lo_out, 32'hFFFFFFFD);
    after_op();
    run_op(0, 32'h80000000, 32'h80000000);
    check("mmin_hi", hi_out, 32'h40000000);
    check("mmin_lo", lo_out, 32'h00000000);
    after_op();
    run_op(1, 32'h80000000, 32'hFFFFFFFF);
    check("dwrap_lo", lo_out, 32'h80000000);
    check("dwrap_hi", hi_out, 32'h00000000);
    after_op();
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("m-1x-1_hi", hi_out, 32'h00000000);
    check("m-1x-1_lo", lo_out, 32'h00000001);
    after_op();

    // Both starts together, then a stray div_start mid-multiply.
    a = $urandom;
    b = $urandom;
    src_a = a;
    src_b = b;
    mult_start = 1'b1;
    div_start  = 1'b1;
    model(0, a, b);
    @(negedge clk);
    mult_start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 45; c++) begin
      if (done) n_done++;
      div_start = (c == 4);
      @(negedge clk);
    end
    div_start = 1'b0;
    check("simul_done_count", n_done, 1);
    check("simul_hi", hi_out, exp_hi);
    check("simul_lo", lo_out, exp_lo);

    // Back-to-back: each new start issued while DONE is showing.
    run_op(0, 32'h00001234, 32'hFFFF0001);
    run_op(1, 32'h7FFFFFFF, 32'h00000003);
    run_op(0, 32'hDEADBEEF, 32'h00000010);
    after_op();

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'(int'($urandom_range(0, 8)) - 4);
        2: a = 32'(int'($urandom_range(0, 200)) - 100);
        default: ;
      endcase
      run_op(i[0], a, b);
      after_op();
    end

    // Reset mid-divide.
    src_a = 32'h12345678;
    src_b = 32'h00000013;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_hi", hi_out, 0);
    check("rst_mid_lo", lo_out, 0);
    check("rst_mid_no_done", seen, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    run_op(0, 32'd3, 32'd4);
    check("m3x4_lo", lo_out, 32'd12);
    check("m3x4_hi", hi_out, 32'd0);
    after_op();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
